// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and constants for the data memory responder
// Contents: state_t (IDLE/BUSY/RESP), WORD_W, LATENCY legal range, latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int WORD_W      = 32;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - synchronous-write, registered-read word array
// Ports: clk_i clock; we write enable; idx word index; wdata write data;
//        re read enable; rdata registered read data (holds when re=0).
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents survive reset by design, so no reset term here.
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory slave for the MEM stage
// Ports: clk_i, rst_i (async, active-high); req_i/we_i/addr_i/wdata_i request
//        from EX_MEM; rdata_o load data, ack_o one-cycle completion, err_o
//        misaligned/out-of-range flag (valid with ack_o); stall_o pipeline hold.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Out-of-range latencies are clamped into the counter's legal range.
  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [29:0]      DEPTH_L  = 30'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              ack_q, err_q, rd_valid_q;

  logic              accept, stall, enter_resp, access;
  logic              acc_we, acc_err, arr_we, arr_re;
  logic [WORD_W-1:0] acc_addr, acc_wdata, arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_i;
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LAT > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // latched copy exists, so the live inputs are used in IDLE.
  always_comb begin
    acc_we    = (state_q == IDLE) ? we_i    : we_q;
    acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
  end

  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_L);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign access     = enter_resp && !rst_i;
  assign arr_we     = access && acc_we && !acc_err;
  assign arr_re     = access && !acc_we && !acc_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      ack_q <= enter_resp;
      err_q <= enter_resp && acc_err;
      if (arr_re) rd_valid_q <= 1'b1;
    end
  end

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i(clk_i),
    .we   (arr_we),
    .idx  (acc_addr[IDX_W+1:2]),
    .wdata(acc_wdata),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

  // The array read register has no reset; rd_valid_q masks it to zero until
  // the first successful load after reset.
  assign rdata_o = rd_valid_q ? arr_rdata : '0;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = stall && !rst_i;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY 4 and 1)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        ack_v   [2];
  logic        err_v   [2];
  logic        stall_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_v[0]), .we_i(we_v[0]), .addr_i(addr_v[0]),
    .wdata_i(wdata_v[0]), .rdata_o(rdata_v[0]), .ack_o(ack_v[0]), .err_o(err_v[0]),
    .stall_o(stall_v[0]));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_v[1]), .we_i(we_v[1]), .addr_i(addr_v[1]),
    .wdata_i(wdata_v[1]), .rdata_o(rdata_v[1]), .ack_o(ack_v[1]), .err_o(err_v[1]),
    .stall_o(stall_v[1]));

  // Drives one request and reports when ack arrives (cycles after the accept
  // edge), err at ack, stall cycles before ack, and stall in the accept cycle.
  // mid=1 keeps req high and changes we/addr/wdata during BUSY.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit mid, output int lat, output logic e, output int stalls,
                     output logic acc_stall);
    @(negedge clk);
    req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
    #1 acc_stall = stall_v[s];
    lat = 0; e = 1'bx; stalls = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_v[s]) begin
        lat = i; e = err_v[s];
        break;
      end
      if (stall_v[s]) stalls++;
      if (mid) begin
        addr_v[s] = 32'h20; we_v[s] = 1'b1; wdata_v[s] = 32'hBAD0BAD0;
      end else begin
        req_v[s] = 1'b0;
      end
    end
    req_v[s] = 1'b0; we_v[s] = 1'b0;
  endtask

  task automatic test_reset();
    req_v[0] = 1'b1; req_v[1] = 1'b1;
    #1;
    n_checks++; if (stall_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_stall4: got %b expected 0", stall_v[0]); end
    n_checks++; if (stall_v[1] !== 1'b0) begin n_fail++; $display("FAIL rst_stall1: got %b expected 0", stall_v[1]); end
    n_checks++; if (ack_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ack_v[0]); end
    n_checks++; if (err_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_v[0]); end
    n_checks++; if (rdata_v[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata_v[0]); end
    @(negedge clk);
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_setup();
    int lat, st; logic e, as;
    logic [31:0] addrs [3] = '{32'h0, 32'h8, 32'h20};
    logic [31:0] vals  [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    for (int k = 0; k < 3; k++) begin
      txn(0, 1'b1, addrs[k], vals[k], 0, lat, e, st, as);
      n_checks++; if (lat !== 4 || e !== 1'b0) begin n_fail++; $display("FAIL setup_store%0d: lat %0d err %b expected lat 4 err 0", k, lat, e); end
    end
  endtask

  task automatic test_store_load();
    int lat, st; logic e, as;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, lat, e, st, as);
    n_checks++; if (as !== 1'b1) begin n_fail++; $display("FAIL st_acc_stall: got %b expected 1", as); end
    n_checks++; if (st !== 3) begin n_fail++; $display("FAIL st_stalls: got %0d expected 3", st); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL st_lat: got %0d expected 4", lat); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL st_err: got %b expected 0", e); end
    n_checks++; if (stall_v[0] !== 1'b0) begin n_fail++; $display("FAIL st_resp_stall: got %b expected 0", stall_v[0]); end
    txn(0, 1'b0, 32'h10, 32'h0, 0, lat, e, st, as);
    n_checks++; if (lat !== 4 || e !== 1'b0) begin n_fail++; $display("FAIL ld_lat_err: lat %0d err %b expected 4 0", lat, e); end
    n_checks++; if (rdata_v[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata: got %h expected deadbeef", rdata_v[0]); end
  endtask

  task automatic test_misaligned();
    int lat, st; logic e, as;
    txn(0, 1'b0, 32'h13, 32'h0, 0, lat, e, st, as);
    n_checks++; if (lat !== 4 || e !== 1'b1) begin n_fail++; $display("FAIL mis_ld: lat %0d err %b expected 4 1", lat, e); end
    n_checks++; if (rdata_v[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_ld_rdata: got %h expected deadbeef", rdata_v[0]); end
    txn(0, 1'b1, 32'h12, 32'h1, 0, lat, e, st, as);
    n_checks++; if (lat !== 4 || e !== 1'b1) begin n_fail++; $display("FAIL mis_st: lat %0d err %b expected 4 1", lat, e); end
    txn(0, 1'b0, 32'h10, 32'h0, 0, lat, e, st, as);
    n_checks++; if (e !== 1'b0 || rdata_v[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_st_nowrite: got %h err %b expected deadbeef 0", rdata_v[0], e); end
  endtask

  task automatic test_out_of_range();
    int lat, st; logic e, as;
    txn(0, 1'b1, 32'h400, 32'hCAFEF00D, 0, lat, e, st, as);
    n_checks++; if (lat !== 4 || e !== 1'b1) begin n_fail++; $display("FAIL oor_st: lat %0d err %b expected 4 1", lat, e); end
    txn(0, 1'b0, 32'h0, 32'h0, 0, lat, e, st, as);
    n_checks++; if (e !== 1'b0 || rdata_v[0] !== 32'h11111111) begin n_fail++; $display("FAIL oor_nowrite: got %h err %b expected 11111111 0", rdata_v[0], e); end
    txn(0, 1'b1, 32'h3FC, 32'h5A5A5A5A, 0, lat, e, st, as);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL last_word_st_err: got %b expected 0", e); end
    txn(0, 1'b0, 32'h3FC, 32'h0, 0, lat, e, st, as);
    n_checks++; if (e !== 1'b0 || rdata_v[0] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL last_word_ld: got %h err %b expected 5a5a5a5a 0", rdata_v[0], e); end
  endtask

  task automatic test_mid_flight();
    int lat, st; logic e, as;
    txn(0, 1'b0, 32'h10, 32'h0, 1, lat, e, st, as);
    n_checks++; if (lat !== 4 || e !== 1'b0) begin n_fail++; $display("FAIL mid_lat_err: lat %0d err %b expected 4 0", lat, e); end
    n_checks++; if (rdata_v[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_rdata: got %h expected deadbeef", rdata_v[0]); end
    txn(0, 1'b0, 32'h20, 32'h0, 0, lat, e, st, as);
    n_checks++; if (rdata_v[0] !== 32'h33333333) begin n_fail++; $display("FAIL mid_word8: got %h expected 33333333", rdata_v[0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mask = '0;
    logic stall_resp, stall_idle;
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      mask[i] = ack_v[0];
      if (i == 4) stall_resp = stall_v[0];
      if (i == 5) stall_idle = stall_v[0];
    end
    req_v[0] = 1'b0;
    n_checks++; if (mask !== 16'h4210) begin n_fail++; $display("FAIL b2b_ack_mask: got %h expected 4210", mask); end
    n_checks++; if (stall_resp !== 1'b0 || stall_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: resp %b idle %b expected 0 1", stall_resp, stall_idle); end
    n_checks++; if (rdata_v[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rdata: got %h expected deadbeef", rdata_v[0]); end
  endtask

  task automatic test_reset_mid();
    int lat, st, acks; logic e, as;
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h8; wdata_v[0] = 32'h12345678;
    @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (stall_v[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b expected 0", stall_v[0]); end
    n_checks++; if (rdata_v[0] !== 32'h0 || ack_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_outs: rdata %h ack %b err %b expected 0 0 0", rdata_v[0], ack_v[0], err_v[0]); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_v[0]) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_noack: got %0d acks expected 0", acks); end
    txn(0, 1'b0, 32'h8, 32'h0, 0, lat, e, st, as);
    n_checks++; if (lat !== 4 || rdata_v[0] !== 32'h22222222) begin n_fail++; $display("FAIL rmid_old: lat %0d rdata %h expected 4 22222222", lat, rdata_v[0]); end
  endtask

  task automatic test_latency1();
    int lat, st; logic e, as;
    txn(1, 1'b1, 32'h4, 32'hA5A5A5A5, 0, lat, e, st, as);
    n_checks++; if (as !== 1'b1 || st !== 0) begin n_fail++; $display("FAIL l1_stall: accept %b busy %0d expected 1 0", as, st); end
    n_checks++; if (lat !== 1 || e !== 1'b0) begin n_fail++; $display("FAIL l1_st: lat %0d err %b expected 1 0", lat, e); end
    n_checks++; if (stall_v[1] !== 1'b0) begin n_fail++; $display("FAIL l1_resp_stall: got %b expected 0", stall_v[1]); end
    txn(1, 1'b0, 32'h4, 32'h0, 0, lat, e, st, as);
    n_checks++; if (lat !== 1 || rdata_v[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL l1_ld: lat %0d rdata %h expected 1 a5a5a5a5", lat, rdata_v[1]); end
    txn(1, 1'b0, 32'h6, 32'h0, 0, lat, e, st, as);
    n_checks++; if (lat !== 1 || e !== 1'b1 || rdata_v[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL l1_mis: lat %0d err %b rdata %h expected 1 1 a5a5a5a5", lat, e, rdata_v[1]); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wdata_v[s] = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_setup();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_mid_flight();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
